// File: rtl/fixed_point_iterative_accumulator.sv
// rtl/fixed_point_iterative_accumulator.sv - sums m fixed-point products into one saturated n-bit result
// Guard bits absorb intermediate excursions; only the final total is clamped on the way out.
module fixed_point_iterative_accumulator #(
  parameter int n    = 32,
  parameter int sign = 0,
  parameter int m    = 8
) (
  input  logic         clk,
  input  logic         reset,
  output logic         recv_rdy,
  input  logic         recv_val,
  input  logic [n-1:0] prod,
  input  logic         send_rdy,
  output logic         send_val,
  output logic [n-1:0] sum,
  output logic         ovf
);

  localparam int G  = (m > 1) ? $clog2(m) : 1;
  localparam int CW = G;
  localparam int AW = n + G;
  localparam logic [CW-1:0] LAST = CW'(m - 1);

  typedef enum logic {S_ACC, S_DONE} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   w_prod_ext;
  logic            w_xfer;

  always_comb begin
    w_prod_ext = {{G{1'b0}}, prod};
    if ((sign != 0) && prod[n-1]) w_prod_ext = {{G{1'b1}}, prod};
  end

  // Handshake outputs come straight from the state register, masked while reset is held.
  assign recv_rdy = ~reset & (r_state == S_ACC);
  assign send_val = ~reset & (r_state == S_DONE);
  assign w_xfer   = recv_val & recv_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_ACC;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_ACC: begin
          if (w_xfer) begin
            r_acc <= r_acc + w_prod_ext;
            if (r_cnt == LAST) begin
              r_cnt   <= '0;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_DONE: begin
          if (send_rdy) begin
            r_acc   <= '0;
            r_state <= S_ACC;
          end
        end
        default: r_state <= S_ACC;
      endcase
    end
  end

  // Signed: the top G+1 bits must all match the sign bit for the total to fit in n bits.
  always_comb begin
    sum = r_acc[n-1:0];
    ovf = 1'b0;
    if (sign != 0) begin
      if (!r_acc[AW-1] && (|r_acc[AW-1:n-1])) begin
        sum = {1'b0, {(n-1){1'b1}}};
        ovf = 1'b1;
      end else if (r_acc[AW-1] && !(&r_acc[AW-1:n-1])) begin
        sum = {1'b1, {(n-1){1'b0}}};
        ovf = 1'b1;
      end
    end else if (|r_acc[AW-1:n]) begin
      sum = '1;
      ovf = 1'b1;
    end
    if (reset) ovf = 1'b0;
  end

endmodule
